// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared state, opcode, alu_op and pc_source definitions for the multicycle control path
package mips_pkg;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_FETCH    = 4'd1,
        ST_DECODE   = 4'd2,
        ST_MEMADR   = 4'd3,
        ST_MEMRD    = 4'd4,
        ST_MEMWB    = 4'd5,
        ST_MEMWR    = 4'd6,
        ST_RTYPE_EX = 4'd7,
        ST_RTYPE_WB = 4'd8,
        ST_BRANCH   = 4'd9,
        ST_JUMP     = 4'd10,
        ST_ADDI_EX  = 4'd11,
        ST_ADDI_WB  = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    // Shared with the ALU control stage so both ends agree on the encoding.
    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    localparam logic [1:0] ALU_B_REG       = 2'b00;
    localparam logic [1:0] ALU_B_FOUR      = 2'b01;
    localparam logic [1:0] ALU_B_IMM       = 2'b10;
    localparam logic [1:0] ALU_B_IMM_SHIFT = 2'b11;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       illegal_op;
    } ctrl_t;

    function automatic logic is_legal_op(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
    endfunction

endpackage

// File: rtl/multicycle_ctrl_decode.sv
// rtl/multicycle_ctrl_decode.sv - combinational state-to-control decode for the multicycle datapath
import mips_pkg::*;

module multicycle_ctrl_decode (
    input  state_t     state,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output ctrl_t      ctrl
);

    // Everything defaults to 0; IDLE and unused encodings keep that default.
    always_comb begin
        ctrl = '0;
        case (state)
            ST_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = ALU_B_FOUR;
                ctrl.alu_op    = ALU_OP_ADD;
                ctrl.pc_source = PC_SRC_ALU;
                // IR and PC only capture once the instruction word has arrived.
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            ST_DECODE: begin
                ctrl.alu_src_b  = ALU_B_IMM_SHIFT;
                ctrl.alu_op     = ALU_OP_ADD;
                ctrl.illegal_op = !is_legal_op(opcode);
            end
            ST_MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = ALU_B_IMM;
                ctrl.alu_op    = ALU_OP_ADD;
            end
            ST_MEMRD: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
            end
            ST_MEMWR: begin
                ctrl.mem_write = 1'b1;
                ctrl.i_or_d    = 1'b1;
            end
            ST_MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            ST_RTYPE_EX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = ALU_B_REG;
                ctrl.alu_op    = ALU_OP_FUNCT;
            end
            ST_RTYPE_WB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            ST_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = ALU_B_REG;
                ctrl.alu_op        = ALU_OP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PC_SRC_ALUOUT;
            end
            ST_JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PC_SRC_JUMP;
            end
            ST_ADDI_EX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = ALU_B_IMM;
                ctrl.alu_op    = ALU_OP_ADD;
            end
            ST_ADDI_WB: begin
                ctrl.reg_write = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_control_32.sv
// rtl/multicycle_control_32.sv - multicycle MIPS control FSM: state register, sequencing and output fan-out
import mips_pkg::*;

module multicycle_control_32 (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic       illegal_op,
    output logic [3:0] state
);

    state_t state_q;
    state_t state_d;
    ctrl_t  ctrl;

    // State register; reset drops to IDLE immediately so no strobe survives.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state sequencing; memory states hold until mem_ready.
    always_comb begin
        state_d = ST_FETCH;
        case (state_q)
            ST_IDLE:  state_d = ST_FETCH;
            ST_FETCH: state_d = mem_ready ? ST_DECODE : ST_FETCH;
            ST_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = ST_MEMADR;
                    OP_RTYPE:     state_d = ST_RTYPE_EX;
                    OP_BEQ:       state_d = ST_BRANCH;
                    OP_J:         state_d = ST_JUMP;
                    OP_ADDI:      state_d = ST_ADDI_EX;
                    default:      state_d = ST_FETCH;
                endcase
            end
            ST_MEMADR:   state_d = (opcode == OP_LW) ? ST_MEMRD : ST_MEMWR;
            ST_MEMRD:    state_d = mem_ready ? ST_MEMWB : ST_MEMRD;
            ST_MEMWB:    state_d = ST_FETCH;
            ST_MEMWR:    state_d = mem_ready ? ST_FETCH : ST_MEMWR;
            ST_RTYPE_EX: state_d = ST_RTYPE_WB;
            ST_RTYPE_WB: state_d = ST_FETCH;
            ST_BRANCH:   state_d = ST_FETCH;
            ST_JUMP:     state_d = ST_FETCH;
            ST_ADDI_EX:  state_d = ST_ADDI_WB;
            ST_ADDI_WB:  state_d = ST_FETCH;
            default:     state_d = ST_FETCH;
        endcase
    end

    multicycle_ctrl_decode u_decode (
        .state     (state_q),
        .opcode    (opcode),
        .mem_ready (mem_ready),
        .ctrl      (ctrl)
    );

    assign pc_write      = ctrl.pc_write;
    assign pc_write_cond = ctrl.pc_write_cond;
    assign i_or_d        = ctrl.i_or_d;
    assign mem_read      = ctrl.mem_read;
    assign mem_write     = ctrl.mem_write;
    assign ir_write      = ctrl.ir_write;
    assign mem_to_reg    = ctrl.mem_to_reg;
    assign reg_dst       = ctrl.reg_dst;
    assign reg_write     = ctrl.reg_write;
    assign alu_src_a     = ctrl.alu_src_a;
    assign alu_src_b     = ctrl.alu_src_b;
    assign alu_op        = ctrl.alu_op;
    assign pc_source     = ctrl.pc_source;
    assign illegal_op    = ctrl.illegal_op;
    assign state         = state_q;

endmodule

// File: tb/tb_multicycle_control_32.sv
// tb/tb_multicycle_control_32.sv - self-checking bench for multicycle_control_32
module tb_multicycle_control_32;

    localparam logic [5:0] T_R    = 6'b000000;
    localparam logic [5:0] T_LW   = 6'b100011;
    localparam logic [5:0] T_SW   = 6'b101011;
    localparam logic [5:0] T_BEQ  = 6'b000100;
    localparam logic [5:0] T_J    = 6'b000010;
    localparam logic [5:0] T_ADDI = 6'b001000;

    localparam logic [3:0] S_IDLE = 4'd0,  S_FETCH = 4'd1,  S_DECODE = 4'd2,  S_MEMADR = 4'd3;
    localparam logic [3:0] S_MEMRD = 4'd4, S_MEMWB = 4'd5,  S_MEMWR = 4'd6,   S_REX = 4'd7;
    localparam logic [3:0] S_RWB = 4'd8,   S_BRANCH = 4'd9, S_JUMP = 4'd10,   S_AEX = 4'd11;
    localparam logic [3:0] S_AWB = 4'd12;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic [3:0] state;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [3:0] st;
        logic       mr;
    } step_t;

    multicycle_control_32 dut (
        .clk(clk), .reset_n(reset_n), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_source(pc_source), .illegal_op(illegal_op), .state(state)
    );

    always #5 clk = ~clk;

    function automatic logic [16:0] obs();
        return {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg,
                reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source, illegal_op};
    endfunction

    function automatic logic legal(input logic [5:0] op);
        logic [5:0] ops [6] = '{T_R, T_LW, T_SW, T_BEQ, T_J, T_ADDI};
        foreach (ops[i]) if (ops[i] == op) return 1'b1;
        return 1'b0;
    endfunction

    // Control word each step must present, read straight off the per-step output table.
    function automatic logic [16:0] exp_ctrl(input logic [3:0] st, input logic mr, input logic [5:0] op);
        logic pw = 0, pwc = 0, iod = 0, rd = 0, wr = 0, irw = 0, m2r = 0, dst = 0, rw = 0, asa = 0, ill = 0;
        logic [1:0] asb = 0, aop = 0, psrc = 0;
        case (st)
            S_FETCH:  begin rd = 1; asb = 2'b01; irw = mr; pw = mr; end
            S_DECODE: begin asb = 2'b11; ill = !legal(op); end
            S_MEMADR: begin asa = 1; asb = 2'b10; end
            S_MEMRD:  begin rd = 1; iod = 1; end
            S_MEMWR:  begin wr = 1; iod = 1; end
            S_MEMWB:  begin rw = 1; m2r = 1; end
            S_REX:    begin asa = 1; aop = 2'b10; end
            S_RWB:    begin rw = 1; dst = 1; end
            S_BRANCH: begin asa = 1; aop = 2'b01; pwc = 1; psrc = 2'b01; end
            S_JUMP:   begin pw = 1; psrc = 2'b10; end
            S_AEX:    begin asa = 1; asb = 2'b10; end
            S_AWB:    begin rw = 1; end
            default:  ;
        endcase
        return {pw, pwc, iod, rd, wr, irw, m2r, dst, rw, asa, asb, aop, psrc, ill};
    endfunction

    task automatic test_reset();
        reset_n = 1'b0; opcode = T_R; mem_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if (obs() !== 17'd0 || state !== S_IDLE) begin
            n_errors++;
            $display("FAIL reset_hold: outputs=%h state=%0d, required 0 and %0d", obs(), state, S_IDLE);
        end
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        n_checks++;
        if (state !== S_IDLE) begin
            n_errors++;
            $display("FAIL reset_release_idle: state=%0d, required %0d", state, S_IDLE);
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (state !== S_FETCH || mem_read !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_first_fetch: state=%0d mem_read=%b, required %0d and 1", state, mem_read, S_FETCH);
        end
        mem_ready = 1'b0;
    endtask

    task automatic test_lw();
        logic [3:0] seq [5] = '{S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB};
        opcode = T_LW;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            mem_ready = 1'b1;
            #1;
            n_checks++;
            if (state !== seq[c] || reg_write !== (c == 4) || mem_to_reg !== (c == 4)) begin
                n_errors++;
                $display("FAIL lw_cycle%0d: state=%0d rw=%b m2r=%b, required %0d %b %b",
                         c + 1, state, reg_write, mem_to_reg, seq[c], c == 4, c == 4);
            end
        end
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        n_checks++;
        if (state !== S_FETCH) begin
            n_errors++;
            $display("FAIL lw_end: state=%0d, required %0d", state, S_FETCH);
        end
    endtask

    task automatic test_rtype();
        logic [3:0] seq [4] = '{S_FETCH, S_DECODE, S_REX, S_RWB};
        opcode = T_R;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            mem_ready = 1'b1;
            #1;
            n_checks++;
            if (state !== seq[c]) begin
                n_errors++;
                $display("FAIL rtype_state%0d: state=%0d, required %0d", c + 1, state, seq[c]);
            end
            if (c == 2) begin
                n_checks++;
                if (alu_op !== 2'b10) begin
                    n_errors++;
                    $display("FAIL rtype_alu_op: alu_op=%b, required 10", alu_op);
                end
            end
            if (c == 3) begin
                n_checks++;
                if (reg_dst !== 1'b1 || reg_write !== 1'b1) begin
                    n_errors++;
                    $display("FAIL rtype_wb: reg_dst=%b reg_write=%b, required 1 1", reg_dst, reg_write);
                end
            end
        end
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        n_checks++;
        if (state !== S_FETCH) begin
            n_errors++;
            $display("FAIL rtype_end: state=%0d, required %0d", state, S_FETCH);
        end
    endtask

    task automatic test_sw_wait();
        int wr_cycles = 0;
        int both_rd_wr = 0;
        opcode = T_SW;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            mem_ready = (c < 3 || c == 6);
            #1;
            if (mem_write === 1'b1) wr_cycles++;
            if (mem_write === 1'b1 && mem_read === 1'b1) both_rd_wr++;
        end
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        n_checks++;
        if (wr_cycles != 4) begin
            n_errors++;
            $display("FAIL sw_write_len: mem_write cycles=%0d, required 4", wr_cycles);
        end
        n_checks++;
        if (both_rd_wr != 0) begin
            n_errors++;
            $display("FAIL sw_rd_wr_overlap: overlap cycles=%0d, required 0", both_rd_wr);
        end
        n_checks++;
        if (state !== S_FETCH) begin
            n_errors++;
            $display("FAIL sw_end: state=%0d after 7 cycles, required %0d", state, S_FETCH);
        end
    endtask

    task automatic test_branch_jump();
        opcode = T_BEQ;
        @(negedge clk); mem_ready = 1'b1;
        @(negedge clk);
        @(negedge clk); #1;
        n_checks++;
        if (state !== S_BRANCH || alu_op !== 2'b01 || pc_write_cond !== 1'b1 || pc_source !== 2'b01) begin
            n_errors++;
            $display("FAIL beq_branch: state=%0d alu_op=%b pwc=%b psrc=%b, required %0d 01 1 01",
                     state, alu_op, pc_write_cond, pc_source, S_BRANCH);
        end
        opcode = T_J;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk); #1;
        n_checks++;
        if (state !== S_JUMP || pc_write !== 1'b1 || pc_source !== 2'b10) begin
            n_errors++;
            $display("FAIL j_jump: state=%0d pc_write=%b psrc=%b, required %0d 1 10",
                     state, pc_write, pc_source, S_JUMP);
        end
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        n_checks++;
        if (state !== S_FETCH) begin
            n_errors++;
            $display("FAIL j_end: state=%0d, required %0d", state, S_FETCH);
        end
    endtask

    task automatic test_illegal();
        opcode = 6'b111111;
        @(negedge clk); mem_ready = 1'b1;
        @(negedge clk); #1;
        n_checks++;
        if (state !== S_DECODE || illegal_op !== 1'b1 || reg_write !== 1'b0 || mem_write !== 1'b0) begin
            n_errors++;
            $display("FAIL illegal_decode: state=%0d ill=%b rw=%b mw=%b, required %0d 1 0 0",
                     state, illegal_op, reg_write, mem_write, S_DECODE);
        end
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        n_checks++;
        if (state !== S_FETCH || illegal_op !== 1'b0 || reg_write !== 1'b0 || mem_write !== 1'b0) begin
            n_errors++;
            $display("FAIL illegal_after: state=%0d ill=%b rw=%b mw=%b, required %0d 0 0 0",
                     state, illegal_op, reg_write, mem_write, S_FETCH);
        end
    endtask

    task automatic test_reset_mid_memrd();
        opcode = T_LW;
        @(negedge clk); mem_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk); mem_ready = 1'b0;
        @(negedge clk); #1;
        n_checks++;
        if (state !== S_MEMRD || mem_read !== 1'b1) begin
            n_errors++;
            $display("FAIL memrd_wait: state=%0d mem_read=%b, required %0d 1", state, mem_read, S_MEMRD);
        end
        #2;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (obs() !== 17'd0 || state !== S_IDLE) begin
            n_errors++;
            $display("FAIL async_reset: outputs=%h state=%0d, required 0 and %0d", obs(), state, S_IDLE);
        end
        @(posedge clk); #1;
        n_checks++;
        if (obs() !== 17'd0 || state !== S_IDLE) begin
            n_errors++;
            $display("FAIL reset_over_edge: outputs=%h state=%0d, required 0 and %0d", obs(), state, S_IDLE);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk); #1;
        n_checks++;
        if (state !== S_FETCH || mem_read !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_restart: state=%0d mem_read=%b, required %0d 1", state, mem_read, S_FETCH);
        end
    endtask

    task automatic test_random();
        step_t      q[$];
        logic [5:0] ops [6] = '{T_R, T_LW, T_SW, T_BEQ, T_J, T_ADDI};
        logic [5:0] op;
        logic [16:0] expv;
        int wf, wm;
        for (int n = 0; n < 80; n++) begin
            int r = $urandom_range(0, 6);
            if (r < 6) op = ops[r];
            else begin
                op = 6'($urandom);
                while (legal(op)) op = 6'($urandom);
            end
            wf = $urandom_range(0, 2);
            wm = $urandom_range(0, 3);
            q.delete();
            for (int i = 0; i < wf; i++) q.push_back('{S_FETCH, 1'b0});
            q.push_back('{S_FETCH, 1'b1});
            q.push_back('{S_DECODE, 1'($urandom)});
            if (op == T_LW || op == T_SW) begin
                q.push_back('{S_MEMADR, 1'($urandom)});
                for (int i = 0; i < wm; i++) q.push_back('{(op == T_LW) ? S_MEMRD : S_MEMWR, 1'b0});
                q.push_back('{(op == T_LW) ? S_MEMRD : S_MEMWR, 1'b1});
                if (op == T_LW) q.push_back('{S_MEMWB, 1'($urandom)});
            end else if (op == T_R) begin
                q.push_back('{S_REX, 1'($urandom)});
                q.push_back('{S_RWB, 1'($urandom)});
            end else if (op == T_ADDI) begin
                q.push_back('{S_AEX, 1'($urandom)});
                q.push_back('{S_AWB, 1'($urandom)});
            end else if (op == T_BEQ) begin
                q.push_back('{S_BRANCH, 1'($urandom)});
            end else if (op == T_J) begin
                q.push_back('{S_JUMP, 1'($urandom)});
            end
            opcode = op;
            foreach (q[i]) begin
                @(negedge clk);
                mem_ready = q[i].mr;
                #1;
                expv = exp_ctrl(q[i].st, q[i].mr, op);
                n_checks++;
                if (state !== q[i].st || obs() !== expv) begin
                    n_errors++;
                    $display("FAIL rand_op%b_step%0d: state=%0d ctrl=%h, required %0d %h",
                             op, i, state, obs(), q[i].st, expv);
                end
                n_checks++;
                if ((mem_write && reg_write) || (mem_write && mem_read)) begin
                    n_errors++;
                    $display("FAIL rand_exclusive: mw=%b rw=%b mr=%b, required no overlap",
                             mem_write, reg_write, mem_read);
                end
            end
            @(negedge clk);
            mem_ready = 1'b0;
            #1;
            n_checks++;
            if (state !== S_FETCH) begin
                n_errors++;
                $display("FAIL rand_end_op%b: state=%0d, required %0d", op, state, S_FETCH);
            end
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_rtype();
        test_sw_wait();
        test_branch_jump();
        test_illegal();
        test_random();
        test_reset_mid_memrd();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
